aes_ingress: RTL and testbench

Front-end stage of the pipelined AES-128 encryptor, directly upstream of the first middle-round stage. It accepts plaintext blocks through a valid/ready handshake and buffers them in a small FIFO. It performs the round-0 AddRoundKey with the held cipher key and issues one pre-whitened block per cycle into the non-stalling round pipeline. It also owns the cipher-key register, the drain-before-rekey control, and a valid delay line that marks when ciphertext leaves the final stage.

---
 rtl/aes_pkg.sv | 13 +
 rtl/aes_ingress_if.sv | 27 ++
 rtl/aes_ingress_fifo.sv | 50 +++++
 rtl/key_add.sv | 12 +
 rtl/aes_ingress.sv | 90 +++++++++
 tb/tb_aes_ingress.sv | 268 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the pipelined AES-128 encryptor.
package aes_pkg;

  localparam int BLOCK_LENGTH = 128;
  localparam int PIPE_DEPTH   = 10;

  typedef enum logic [1:0] {
    NO_KEY = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } ingress_state_e;

endpackage

// File: rtl/aes_ingress_if.sv
// Plaintext/key handshake bundle between the block source and the AES ingress stage.
interface aes_ingress_if
  import aes_pkg::*;
();

  logic                    in_valid;
  logic                    in_ready;
  logic [BLOCK_LENGTH-1:0] IN;
  logic                    key_valid;
  logic                    key_ready;
  logic [BLOCK_LENGTH-1:0] KEY_IN;
  logic [BLOCK_LENGTH-1:0] KEY_OUT;
  logic [BLOCK_LENGTH-1:0] OUT;
  logic                    out_valid;
  logic                    ct_valid;

  modport master (
    output in_valid, IN, key_valid, KEY_IN,
    input  in_ready, key_ready, KEY_OUT, OUT, out_valid, ct_valid
  );

  modport slave (
    input  in_valid, IN, key_valid, KEY_IN,
    output in_ready, key_ready, KEY_OUT, OUT, out_valid, ct_valid
  );

endinterface

// File: rtl/aes_ingress_fifo.sv
// Small synchronous plaintext FIFO; caller must not push when full or pop when empty.
module aes_ingress_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= bump(wr_q);
      if (pop_i)  rd_q <= bump(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/key_add.sv
// AddRoundKey: bitwise XOR of the state with a round key.
module key_add #(
  parameter int W = 128
) (
  input  logic [W-1:0] state_i,
  input  logic [W-1:0] key_i,
  output logic [W-1:0] out_o
);

  assign out_o = state_i ^ key_i;

endmodule

// File: rtl/aes_ingress.sv
// AES-128 ingress: plaintext buffering, round-0 AddRoundKey, cipher-key ownership,
// drain-before-rekey control and the ciphertext-valid delay line.
module aes_ingress
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  aes_ingress_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ingress_state_e          state_q;
  logic [BLOCK_LENGTH-1:0] key_q;
  logic [BLOCK_LENGTH-1:0] out_q;
  logic [BLOCK_LENGTH-1:0] out_d;
  logic                    out_valid_q;
  logic [PIPE_DEPTH-1:0]   dl_q;

  logic [BLOCK_LENGTH-1:0] fifo_head;
  logic [CW-1:0]           fifo_count;
  logic                    in_ready;
  logic                    push;
  logic                    issue;
  logic                    pipe_empty;
  logic                    key_ready;
  logic                    key_hs;

  assign in_ready   = fifo_count < CW'(FIFO_DEPTH);
  assign push       = bus.in_valid && in_ready;
  assign issue      = (state_q == RUN) && (fifo_count != '0);
  // A new key is only taken once nothing keyed with the old one remains in the rounds.
  assign pipe_empty = !out_valid_q && (dl_q == '0);
  assign key_ready  = (state_q == NO_KEY) || ((state_q == DRAIN) && pipe_empty);
  assign key_hs     = bus.key_valid && key_ready;

  aes_ingress_fifo #(
    .WIDTH (BLOCK_LENGTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (bus.IN),
    .pop_i   (issue),
    .rdata_o (fifo_head),
    .count_o (fifo_count)
  );

  key_add #(
    .W (BLOCK_LENGTH)
  ) u_round0 (
    .state_i (fifo_head),
    .key_i   (key_q),
    .out_o   (out_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= NO_KEY;
      key_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      dl_q        <= '0;
    end else begin
      dl_q        <= {dl_q[PIPE_DEPTH-2:0], out_valid_q};
      out_valid_q <= issue;
      if (issue)  out_q <= out_d;
      if (key_hs) key_q <= bus.KEY_IN;
      case (state_q)
        NO_KEY:  if (key_hs) state_q <= RUN;
        RUN:     if (bus.key_valid) state_q <= DRAIN;
        // Leave DRAIN with a fresh key, or with the old one if the request is withdrawn.
        DRAIN:   if (key_hs || !bus.key_valid) state_q <= RUN;
        default: state_q <= NO_KEY;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.key_ready = key_ready;
  assign bus.KEY_OUT   = key_q;
  assign bus.OUT       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ct_valid  = dl_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_aes_ingress.sv
// Directed bench for aes_ingress: key load, keyless buffering, streaming, rekey and reset.
module tb_aes_ingress;
  import aes_pkg::*;

  localparam int PD = PIPE_DEPTH;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] X1  = 128'h00102030405060708090a0b0c0d0e0f0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passes = 0;
  int   fails  = 0;
  int   checks = 0;

  aes_ingress_if bus();

  aes_ingress #(.FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.key_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] blk(input int n);
    return {4{32'hA5A50000 | 32'(n)}};
  endfunction

  initial begin
    int cyc, idx, run, max_run, ct_cnt, ov_cnt, rdy_bad;
    logic ct_seen;

    bus.in_valid  = 1'b0;
    bus.IN        = '0;
    bus.key_valid = 1'b0;
    bus.KEY_IN    = '0;

    // Reset values
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk ("rst_out",       bus.OUT, '0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_ct_valid",  bus.ct_valid, 1'b0);
    chk ("rst_key_out",   bus.KEY_OUT, '0);
    chk1("rst_in_ready",  bus.in_ready, 1'b1);
    chk1("rst_key_ready", bus.key_ready, 1'b1);

    // Known-answer round-0 XOR and latency
    bus.key_valid = 1'b1;
    bus.KEY_IN    = K1;
    step();
    idle();
    chk ("t1_key_loaded", bus.KEY_OUT, K1);
    chk1("t1_key_ready_run", bus.key_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.IN       = P1;
    step();
    idle();
    chk1("t1_ov_at_accept", bus.out_valid, 1'b0);
    step();
    chk1("t1_ov", bus.out_valid, 1'b1);
    chk ("t1_out", bus.OUT, X1);
    cyc = 0;
    while (!bus.ct_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chkn("t1_ct_latency", cyc, PD);
    step();
    chk1("t1_ct_single", bus.ct_valid, 1'b0);

    // Keyless buffering, then in-order issue after key load
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.IN = blk(1);
    step();
    bus.IN = blk(2);
    step();
    bus.IN = blk(3);
    chk1("t2_full_in_ready", bus.in_ready, 1'b0);
    chk1("t2_no_issue", bus.out_valid, 1'b0);
    step();
    chk1("t2_still_full", bus.in_ready, 1'b0);
    chk1("t2_still_no_issue", bus.out_valid, 1'b0);
    bus.key_valid = 1'b1;
    bus.KEY_IN    = K1;
    step();
    bus.key_valid = 1'b0;
    chk1("t2_full_after_key", bus.in_ready, 1'b0);
    step();
    chk1("t2_ov_a", bus.out_valid, 1'b1);
    chk ("t2_out_a", bus.OUT, blk(1) ^ K1);
    chk1("t2_ready_after_pop", bus.in_ready, 1'b1);
    step();
    idle();
    chk ("t2_out_b", bus.OUT, blk(2) ^ K1);
    step();
    chk1("t2_ov_c", bus.out_valid, 1'b1);
    chk ("t2_out_c", bus.OUT, blk(3) ^ K1);
    step();
    chk1("t2_ov_end", bus.out_valid, 1'b0);
    repeat (PD + 2) step();

    // 20 back-to-back blocks
    idx = 0; run = 0; max_run = 0; ct_cnt = 0; rdy_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 20) begin
        bus.in_valid = 1'b1;
        bus.IN = blk(c + 10);
        if (!bus.in_ready) rdy_bad++;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.out_valid) begin
        chk("t3_stream_out", bus.OUT, blk(idx + 10) ^ K1);
        idx++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus.ct_valid) ct_cnt++;
    end
    chkn("t3_in_ready_drops", rdy_bad, 0);
    chkn("t3_issued", idx, 20);
    chkn("t3_consecutive", max_run, 20);
    chkn("t3_ct_pulses", ct_cnt, 20);

    // Rekey mid-stream
    bus.in_valid = 1'b1;
    bus.IN = blk(100);
    step();
    bus.IN = blk(101);
    step();
    bus.IN = blk(102);
    bus.key_valid = 1'b1;
    bus.KEY_IN = K2;
    chk1("t4_key_ready_run", bus.key_ready, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk1("t4_last_issue_ov", bus.out_valid, 1'b1);
    chk ("t4_last_issue_out", bus.OUT, blk(101) ^ K1);
    step();
    chk1("t4_drain_no_issue", bus.out_valid, 1'b0);
    chk ("t4_old_key_held", bus.KEY_OUT, K1);
    cyc = 0;
    ct_seen = 1'b0;
    while (!bus.key_ready && cyc < 40) begin
      step();
      cyc++;
      if (bus.ct_valid) ct_seen = 1'b1;
    end
    chkn("t4_drain_cycles", cyc, PD);
    chk1("t4_ct_seen", ct_seen, 1'b1);
    chk1("t4_ct_clear", bus.ct_valid, 1'b0);
    step();
    bus.key_valid = 1'b0;
    chk ("t4_new_key", bus.KEY_OUT, K2);
    chk1("t4_no_issue_at_load", bus.out_valid, 1'b0);
    step();
    chk1("t4_ov_new_key", bus.out_valid, 1'b1);
    chk ("t4_out_new_key", bus.OUT, blk(102) ^ K2);

    // One-cycle key_valid pulse in RUN
    bus.in_valid = 1'b1;
    bus.IN = blk(200);
    step();
    bus.IN = blk(201);
    bus.key_valid = 1'b1;
    bus.KEY_IN = K3;
    step();
    idle();
    chk1("t5_ov_first", bus.out_valid, 1'b1);
    chk ("t5_out_first", bus.OUT, blk(200) ^ K2);
    step();
    chk1("t5_drain_gap", bus.out_valid, 1'b0);
    step();
    chk1("t5_ov_second", bus.out_valid, 1'b1);
    chk ("t5_out_second", bus.OUT, blk(201) ^ K2);
    chk ("t5_key_kept", bus.KEY_OUT, K2);
    step();
    chk1("t5_no_dup", bus.out_valid, 1'b0);

    // Reset with 4 blocks in flight and 2 buffered
    for (int c = 0; c < 6; c++) begin
      bus.in_valid  = 1'b1;
      bus.IN        = blk(300 + c);
      bus.key_valid = (c == 4);
      bus.KEY_IN    = K3;
      step();
    end
    idle();
    chk1("t6_pre_full", bus.in_ready, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk ("t6_out", bus.OUT, '0);
    chk1("t6_out_valid", bus.out_valid, 1'b0);
    chk1("t6_ct_valid", bus.ct_valid, 1'b0);
    chk ("t6_key_out", bus.KEY_OUT, '0);
    chk1("t6_in_ready", bus.in_ready, 1'b1);
    chk1("t6_key_ready", bus.key_ready, 1'b1);
    ct_cnt = 0;
    ov_cnt = 0;
    for (int c = 0; c < 2 * PD; c++) begin
      step();
      if (bus.ct_valid) ct_cnt++;
      if (bus.out_valid) ov_cnt++;
    end
    chkn("t6_ct_after_reset", ct_cnt, 0);
    chkn("t6_ov_after_reset", ov_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
